// File: rtl/lc3b_types.sv
// Shared LC-3b types for the branch resolution queue: word type, queue geometry,
// entry layout, FSM states and a saturating counter helper.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam int BRQ_DEPTH = 4;
  localparam int BRQ_PTR_W = 2;
  localparam int BRQ_CNT_W = 3;

  typedef struct packed {
    lc3b_word pc;
    logic     predict_taken;
  } brq_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FLUSH  = 1'b1
  } brq_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/brq_fifo.sv
// In-order storage for in-flight branches. Head read bypasses to the incoming
// entry when empty so a same-cycle push and pop at empty resolves that branch.
module brq_fifo
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  logic [15:0] i_wpc,
  input  logic        i_wpt,
  output logic [15:0] o_head_pc,
  output logic        o_head_pt,
  output logic        o_empty,
  output logic        o_full
);

  brq_entry_t                 r_mem [BRQ_DEPTH];
  logic [BRQ_PTR_W-1:0]       r_head;
  logic [BRQ_PTR_W-1:0]       r_tail;
  logic [BRQ_CNT_W-1:0]       r_count;
  brq_entry_t                 w_head;
  logic                       w_empty;

  assign w_empty   = (r_count == 3'd0);
  assign o_empty   = w_empty;
  assign o_full    = (r_count == 3'd4);
  assign o_head_pc = w_head.pc;
  assign o_head_pt = w_head.predict_taken;

  // Head selection with empty-queue bypass.
  always_comb begin
    w_head = r_mem[r_head];
    if (w_empty) begin
      w_head = '{pc: i_wpc, predict_taken: i_wpt};
    end else begin
      w_head = r_mem[r_head];
    end
  end

  // Pointers and occupancy; a flush discards everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      r_count <= 3'd0;
    end else if (i_flush) begin
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (i_push) begin
        r_tail <= r_tail + 2'd1;
      end else begin
        r_tail <= r_tail;
      end
      if (i_pop) begin
        r_head <= r_head + 2'd1;
      end else begin
        r_head <= r_head;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage, not reset.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_tail] <= '{pc: i_wpc, predict_taken: i_wpt};
    end
  end

endmodule

// File: rtl/branch_resolution_queue.sv
// Tracks predicted branches from fetch to writeback, reports outcomes to the
// predictor, flushes on mispredict and keeps saturating performance counters.
module branch_resolution_queue
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_branch_valid,
  input  logic [15:0] fetch_pc,
  input  logic        fetch_predict_taken,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic        queue_full,
  output logic        update_branch_history,
  output logic        wb_take_jump,
  output logic [15:0] resolved_pc,
  output logic        mispredict,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count,
  output logic        protocol_error
);

  brq_state_e  r_state;
  brq_state_e  w_state_nxt;
  logic        r_update;
  logic        r_take;
  logic [15:0] r_pc;
  logic        r_mis;
  logic [15:0] r_branch_cnt;
  logic [15:0] r_mis_cnt;
  logic        r_err;

  logic        w_empty;
  logic        w_full;
  logic [15:0] w_head_pc;
  logic        w_head_pt;
  logic        w_push_req;
  logic        w_pop;
  logic        w_mis;
  logic        w_push;
  logic        w_err;

  brq_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_mis),
    .i_wpc     (fetch_pc),
    .i_wpt     (fetch_predict_taken),
    .o_head_pc (w_head_pc),
    .o_head_pt (w_head_pt),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  // Push/pop qualification; a pop at empty is legal only against a same-cycle push.
  always_comb begin
    w_push_req = fetch_branch_valid && (r_state == NORMAL);
    w_pop      = resolve_valid && (!w_empty || w_push_req);
    w_mis      = w_pop && (w_head_pt != resolve_taken);
    w_push     = w_push_req && (!w_full || w_pop) && !w_mis;
    w_err      = (resolve_valid && !w_pop) || (w_push_req && w_full && !w_pop);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: FLUSH is a single cycle following a mispredicting pop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      NORMAL: begin
        if (w_mis) begin
          w_state_nxt = FLUSH;
        end else begin
          w_state_nxt = NORMAL;
        end
      end
      FLUSH:   w_state_nxt = NORMAL;
      default: w_state_nxt = NORMAL;
    endcase
  end

  // Registered resolution outputs, counters and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_update     <= 1'b0;
      r_take       <= 1'b0;
      r_pc         <= 16'h0000;
      r_mis        <= 1'b0;
      r_branch_cnt <= 16'h0000;
      r_mis_cnt    <= 16'h0000;
      r_err        <= 1'b0;
    end else begin
      r_update <= w_pop;
      r_mis    <= w_mis;
      r_err    <= r_err | w_err;
      if (w_pop) begin
        r_take       <= resolve_taken;
        r_pc         <= w_head_pc;
        r_branch_cnt <= sat_inc16(r_branch_cnt);
      end else begin
        r_take       <= r_take;
        r_pc         <= r_pc;
        r_branch_cnt <= r_branch_cnt;
      end
      if (w_mis) begin
        r_mis_cnt <= sat_inc16(r_mis_cnt);
      end else begin
        r_mis_cnt <= r_mis_cnt;
      end
    end
  end

  assign queue_full            = w_full;
  assign update_branch_history = r_update;
  assign wb_take_jump          = r_take;
  assign resolved_pc           = r_pc;
  assign mispredict            = r_mis;
  assign branch_count          = r_branch_cnt;
  assign mispredict_count      = r_mis_cnt;
  assign protocol_error        = r_err;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed self-checking bench for branch_resolution_queue.
module tb_branch_resolution_queue;

  logic        clk;
  logic        reset_n;
  logic        fetch_branch_valid;
  logic [15:0] fetch_pc;
  logic        fetch_predict_taken;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        queue_full;
  logic        update_branch_history;
  logic        wb_take_jump;
  logic [15:0] resolved_pc;
  logic        mispredict;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;
  logic        protocol_error;

  int n_vec;
  int n_miss;

  branch_resolution_queue dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .fetch_branch_valid    (fetch_branch_valid),
    .fetch_pc              (fetch_pc),
    .fetch_predict_taken   (fetch_predict_taken),
    .resolve_valid         (resolve_valid),
    .resolve_taken         (resolve_taken),
    .queue_full            (queue_full),
    .update_branch_history (update_branch_history),
    .wb_take_jump          (wb_take_jump),
    .resolved_pc           (resolved_pc),
    .mispredict            (mispredict),
    .branch_count          (branch_count),
    .mispredict_count      (mispredict_count),
    .protocol_error        (protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_branch_valid  = 1'b0;
    fetch_pc            = 16'h0000;
    fetch_predict_taken = 1'b0;
    resolve_valid       = 1'b0;
    resolve_taken       = 1'b0;
  endtask

  task automatic push(input logic [15:0] pc, input logic pt);
    fetch_branch_valid  = 1'b1;
    fetch_pc            = pc;
    fetch_predict_taken = pt;
  endtask

  task automatic resolve(input logic taken);
    resolve_valid = 1'b1;
    resolve_taken = taken;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".full"},   {31'd0, queue_full},            32'd0);
    chk({tag, ".upd"},    {31'd0, update_branch_history}, 32'd0);
    chk({tag, ".take"},   {31'd0, wb_take_jump},          32'd0);
    chk({tag, ".pc"},     {16'd0, resolved_pc},           32'd0);
    chk({tag, ".mis"},    {31'd0, mispredict},            32'd0);
    chk({tag, ".bcnt"},   {16'd0, branch_count},          32'd0);
    chk({tag, ".mcnt"},   {16'd0, mispredict_count},      32'd0);
    chk({tag, ".perr"},   {31'd0, protocol_error},        32'd0);
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    reset_n = 1'b0;
    idle();
    tick();
    tick();
    chk_zero("rst");
    reset_n = 1'b1;
    tick();

    // single correctly predicted branch
    push(16'h3000, 1'b1);
    tick();
    idle();
    chk("t1.full", {31'd0, queue_full}, 32'd0);
    resolve(1'b1);
    tick();
    idle();
    chk("t1.upd",  {31'd0, update_branch_history}, 32'd1);
    chk("t1.pc",   {16'd0, resolved_pc},           32'h3000);
    chk("t1.take", {31'd0, wb_take_jump},          32'd1);
    chk("t1.mis",  {31'd0, mispredict},            32'd0);
    chk("t1.bcnt", {16'd0, branch_count},          32'd1);
    tick();
    chk("t1.upd_pulse", {31'd0, update_branch_history}, 32'd0);

    // mispredict flushes three entries; push in FLUSH dropped silently
    push(16'h3000, 1'b0); tick();
    push(16'h3002, 1'b0); tick();
    push(16'h3004, 1'b0); tick();
    idle();
    resolve(1'b1);
    tick();
    idle();
    chk("t2.upd",  {31'd0, update_branch_history}, 32'd1);
    chk("t2.pc",   {16'd0, resolved_pc},           32'h3000);
    chk("t2.mis",  {31'd0, mispredict},            32'd1);
    chk("t2.mcnt", {16'd0, mispredict_count},      32'd1);
    chk("t2.bcnt", {16'd0, branch_count},          32'd2);
    push(16'h3006, 1'b0);
    tick();
    idle();
    chk("t2.mis_pulse", {31'd0, mispredict},     32'd0);
    chk("t2.perr",      {31'd0, protocol_error}, 32'd0);

    // fill from empty: full exactly after the fourth push
    push(16'h4000, 1'b1); tick();
    push(16'h4002, 1'b0); tick();
    push(16'h4004, 1'b1); tick();
    chk("t3.full3", {31'd0, queue_full}, 32'd0);
    push(16'h4006, 1'b0); tick();
    chk("t3.full4", {31'd0, queue_full}, 32'd1);
    push(16'h4008, 1'b1); tick();
    idle();
    chk("t3.full5", {31'd0, queue_full},     32'd1);
    chk("t3.perr",  {31'd0, protocol_error}, 32'd1);
    push(16'h4008, 1'b1);
    resolve(1'b1);
    tick();
    idle();
    chk("t3.pp_full", {31'd0, queue_full},            32'd1);
    chk("t3.pp_upd",  {31'd0, update_branch_history}, 32'd1);
    chk("t3.pp_pc",   {16'd0, resolved_pc},           32'h4000);
    chk("t3.pp_mis",  {31'd0, mispredict},            32'd0);
    chk("t3.pp_bcnt", {16'd0, branch_count},          32'd3);
    resolve(1'b0); tick();
    chk("t3.d0_pc", {16'd0, resolved_pc}, 32'h4002);
    resolve(1'b1); tick();
    chk("t3.d1_pc", {16'd0, resolved_pc}, 32'h4004);
    resolve(1'b0); tick();
    chk("t3.d2_pc", {16'd0, resolved_pc}, 32'h4006);
    resolve(1'b1); tick();
    idle();
    chk("t3.d3_pc",   {16'd0, resolved_pc},      32'h4008);
    chk("t3.d3_take", {31'd0, wb_take_jump},     32'd1);
    chk("t3.d3_full", {31'd0, queue_full},       32'd0);
    chk("t3.bcnt",    {16'd0, branch_count},     32'd7);
    chk("t3.mcnt",    {16'd0, mispredict_count}, 32'd1);

    // resolve on empty queue
    do_reset();
    resolve(1'b1);
    tick();
    idle();
    chk("t4.upd",  {31'd0, update_branch_history}, 32'd0);
    chk("t4.bcnt", {16'd0, branch_count},          32'd0);
    chk("t4.perr", {31'd0, protocol_error},        32'd1);

    // push and resolve together at empty resolve the incoming branch
    push(16'h5000, 1'b1);
    resolve(1'b1);
    tick();
    idle();
    chk("t5.upd",  {31'd0, update_branch_history}, 32'd1);
    chk("t5.pc",   {16'd0, resolved_pc},           32'h5000);
    chk("t5.mis",  {31'd0, mispredict},            32'd0);
    chk("t5.bcnt", {16'd0, branch_count},          32'd1);
    chk("t5.full", {31'd0, queue_full},            32'd0);

    // counter saturation
    do_reset();
    push(16'h6000, 1'b0);
    resolve(1'b0);
    for (int i = 0; i < 65534; i++) begin
      tick();
    end
    chk("t6.bcnt_fffe", {16'd0, branch_count}, 32'hFFFE);
    tick();
    chk("t6.bcnt_ffff", {16'd0, branch_count}, 32'hFFFF);
    tick();
    chk("t6.bcnt_hold", {16'd0, branch_count}, 32'hFFFF);
    chk("t6.upd_pend",  {31'd0, update_branch_history}, 32'd1);

    // asynchronous reset mid-stream, between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("t7.async");
    idle();
    tick();
    reset_n = 1'b1;
    tick();
    chk("t7.upd_after", {31'd0, update_branch_history}, 32'd0);
    chk("t7.mis_after", {31'd0, mispredict},            32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
